// File: rtl/prog_loader.sv
// prog_loader -- boot-time program loader in front of the riscv core.
//
// Accepts a framed word stream (header N, N payload words, XOR checksum),
// writes the payload to instruction memory starting at word address 0,
// waits SETTLE_CYCLES after a good checksum and then raises fetch_enable_o.
// A bad header or checksum latches err_o and fetch stays disabled.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_i         one-cycle pulse requesting a new load (IDLE/RUN/ERR only)
//   s_valid_i       stream word valid
//   s_data_i        stream word
//   s_ready_o       loader can accept a word (HDR/LOAD/CHK)
//   mem_we_o        registered instruction-memory write strobe
//   mem_addr_o      registered write word address
//   mem_wdata_o     registered write data
//   fetch_enable_o  drives the core's fetch_enable_i (held in RUN)
//   busy_o          load in progress (HDR/LOAD/CHK/SETTLE)
//   done_o          last load completed successfully
//   err_o           last load failed
//
// Handshake: a beat transfers on a rising edge where s_valid_i && s_ready_o.
// s_ready_o depends only on the FSM state, never on s_valid_i, and the
// producer may drop s_valid_i between any two beats.
module prog_loader #(
  parameter int ADDR_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  s_valid_i,
  input  logic [31:0]           s_data_i,
  output logic                  s_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  fetch_enable_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // Word count needs one extra bit so that a full-memory load (N == DEPTH)
  // is representable.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_W-1:0]      DEPTH_N     = CNT_W'(1) << ADDR_WIDTH;
  localparam logic [CNT_W-1:0]      ONE_N       = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A       = ADDR_WIDTH'(1);
  localparam logic [SET_W-1:0]      ONE_S       = SET_W'(1);
  localparam logic [SET_W-1:0]      SETTLE_LOAD = SET_W'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_CHK    = 3'd3,
    ST_SETTLE = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // FSM state, kept as a named signal so checkers can bind to it.
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      rem_q, rem_d;        // payload words still expected
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;      // address of the next payload word
  logic [31:0]           xor_q, xor_d;        // running checksum
  logic [SET_W-1:0]      settle_q, settle_d;  // settle countdown
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  fetch_q, fetch_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic             s_ready;
  logic             accept;
  logic [CNT_W-1:0] hdr_n;
  logic             hdr_bad;

  assign s_ready = (state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CHK);
  assign accept  = s_valid_i && s_ready;

  // Header: N in the low ADDR_WIDTH+1 bits; everything above must be zero.
  assign hdr_n   = s_data_i[ADDR_WIDTH:0];
  assign hdr_bad = (hdr_n == '0) || (hdr_n > DEPTH_N) || (|s_data_i[31:ADDR_WIDTH+1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      addr_q   <= '0;
      xor_q    <= '0;
      settle_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      fetch_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      xor_q    <= xor_d;
      settle_q <= settle_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      fetch_q  <= fetch_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    xor_d    = xor_q;
    settle_d = settle_q;
    we_d     = 1'b0;       // strobe is a single-cycle pulse per payload beat
    waddr_d  = waddr_q;    // address/data hold their last values
    wdata_d  = wdata_q;
    fetch_d  = fetch_q;
    done_d   = done_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        fetch_d = 1'b0;
        if (start_i) state_d = ST_HDR;
      end

      ST_HDR: begin
        if (accept) begin
          if (hdr_bad) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            rem_d   = hdr_n;
            addr_d  = '0;
            xor_d   = '0;
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          xor_d   = xor_q ^ s_data_i;
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = s_data_i;
          rem_d   = rem_q - ONE_N;
          if (rem_q == ONE_N) begin
            // Last word: leave the address on the final slot rather than
            // letting a full-depth load roll it over to 0.
            state_d = ST_CHK;
          end else begin
            addr_d = addr_q + ONE_A;
          end
        end
      end

      ST_CHK: begin
        if (accept) begin
          if (s_data_i == xor_q) begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_LOAD;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        // Counter goes SETTLE_CYCLES..1; fetch is registered on the edge
        // where it reaches 0, i.e. SETTLE_CYCLES edges after the checksum.
        settle_d = settle_q - ONE_S;
        if (settle_q == ONE_S) begin
          state_d = ST_RUN;
          fetch_d = 1'b1;
          done_d  = 1'b1;
        end
      end

      ST_RUN: begin
        if (start_i) begin
          state_d = ST_HDR;
          fetch_d = 1'b0;
          done_d  = 1'b0;
        end
      end

      ST_ERR: begin
        if (start_i) begin
          state_d = ST_HDR;
          err_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign s_ready_o      = s_ready;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = waddr_q;
  assign mem_wdata_o    = wdata_q;
  assign fetch_enable_o = fetch_q;
  assign busy_o         = (state_q == ST_HDR) || (state_q == ST_LOAD) ||
                          (state_q == ST_CHK) || (state_q == ST_SETTLE);
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (ADDR_WIDTH=8, SETTLE_CYCLES=4).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// either at that point or on the falling edge.
module tb_prog_loader;

  localparam int AW     = 8;
  localparam int SETTLE = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic          s_valid_i = 1'b0;
  logic [31:0]   s_data_i = '0;
  logic          s_ready_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          fetch_enable_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_WIDTH(AW), .SETTLE_CYCLES(SETTLE)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .s_valid_i      (s_valid_i),
    .s_data_i       (s_data_i),
    .s_ready_o      (s_ready_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .fetch_enable_o (fetch_enable_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // number of rising edges seen

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [AW+31:0] exp_q[$];      // {addr, data} of each expected write
  int             exp_cyc_q[$];  // edge count at which the beat was accepted
  logic [AW-1:0]  exp_addr;
  int             last_acc_cyc;
  logic [AW+31:0] mon_e;
  int             mon_c;

  // Every strobe must match the next expected write and appear in the cycle
  // right after its beat was accepted (so never in a stall cycle).
  always @(negedge clk) begin
    if (!rst && mem_we_o) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write",
               mem_addr_o, mem_wdata_o);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        checks++;
        assert ({mem_addr_o, mem_wdata_o} === mon_e) else begin
          failures++;
          $error("FAIL write_addr_data observed=%0h expected=%0h",
                 {mem_addr_o, mem_wdata_o}, mon_e);
        end
        checks++;
        assert (cyc === mon_c) else begin
          failures++;
          $error("FAIL write_cycle observed=%0d expected=%0d", cyc, mon_c);
        end
      end
    end
    if (!rst && (done_o || err_o)) begin
      checks++;
      assert (!(done_o && err_o)) else begin
        failures++;
        $error("FAIL done_err_exclusive observed done=%0b err=%0b expected not both",
               done_o, err_o);
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, s_ready_o, 0);
    check({tag, "_mem_we"}, mem_we_o, 0);
    check({tag, "_mem_addr"}, mem_addr_o, 0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 0);
    check({tag, "_fetch"}, fetch_enable_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  task automatic start_load();
    exp_addr = '0;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
  endtask

  // Present one word after 'gap' idle cycles and hold it until accepted.
  task automatic send_word(input logic [31:0] w, input bit is_data, input int gap);
    bit acc;
    int budget;
    acc    = 1'b0;
    budget = 0;
    s_valid_i = 1'b0;
    repeat (gap) tick();
    s_valid_i = 1'b1;
    s_data_i  = w;
    while (!acc && budget < 16) begin
      acc = s_ready_o;
      tick();
      budget++;
    end
    s_valid_i = 1'b0;
    check("accept_timeout", acc, 1);
    last_acc_cyc = cyc;
    if (acc && is_data) begin
      exp_q.push_back({exp_addr, w});
      exp_cyc_q.push_back(cyc);
      exp_addr++;
    end
  endtask

  // Fetch must rise exactly SETTLE edges after the checksum edge.
  task automatic check_settle(input string tag);
    repeat (SETTLE - 1) tick();
    check({tag, "_fetch_early"}, fetch_enable_o, 0);
    check({tag, "_busy_settle"}, busy_o, 1);
    tick();
    check({tag, "_fetch_rise"}, fetch_enable_o, 1);
    check({tag, "_done"}, done_o, 1);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_busy_run"}, busy_o, 0);
  endtask

  task automatic check_err(input string tag);
    check({tag, "_err"}, err_o, 1);
    check({tag, "_fetch"}, fetch_enable_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] big_xor;
    logic [31:0] w;

    // Reset is asserted before the first clock edge: outputs clear asynchronously.
    #2 rst = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Frame 1, continuous valid. XOR of the three words is 0x001000F3.
    start_load();
    check("f1_busy_after_start", busy_o, 1);
    check("f1_ready_in_hdr", s_ready_o, 1);
    send_word(32'd3, 1'b0, 0);
    send_word(32'h0000_0013, 1'b1, 0);
    send_word(32'h0010_0093, 1'b1, 0);
    send_word(32'h0000_0073, 1'b1, 0);
    send_word(32'h0010_00F3, 1'b0, 0);
    check_settle("f1");

    // Restart from RUN: fetch and done drop with the start edge.
    start_load();
    check("f2_fetch_drop", fetch_enable_o, 0);
    check("f2_done_drop", done_o, 0);
    check("f2_busy", busy_o, 1);
    // Same frame with valid low every other cycle.
    send_word(32'd3, 1'b0, 1);
    send_word(32'h0000_0013, 1'b1, 1);
    send_word(32'h0010_0093, 1'b1, 1);
    send_word(32'h0000_0073, 1'b1, 1);
    send_word(32'h0010_00F3, 1'b0, 1);
    check_settle("f2");

    // Bad headers: zero, DEPTH+1, and a nonzero bit above the count field.
    start_load();
    send_word(32'd0, 1'b0, 0);
    check_err("hdr0");
    repeat (3) tick();
    check("hdr0_err_held", err_o, 1);
    check("hdr0_ready", s_ready_o, 0);
    start_load();
    check("hdr257_err_clear", err_o, 0);
    send_word(32'd257, 1'b0, 0);
    check_err("hdr257");
    start_load();
    send_word(32'h0000_0201, 1'b0, 0);
    check_err("hdr_hi");

    // Checksum off by one bit: A5A5A5A5 ^ 0F0F0F0F = AAAAAAAA.
    start_load();
    send_word(32'd2, 1'b0, 0);
    send_word(32'hA5A5_A5A5, 1'b1, 0);
    send_word(32'h0F0F_0F0F, 1'b1, 0);
    send_word(32'hAAAA_AAAB, 1'b0, 0);
    tick();
    check_err("bad_cks");
    check("bad_cks_writes_done", exp_q.size(), 0);
    start_load();
    send_word(32'd1, 1'b0, 0);
    send_word(32'h1234_5678, 1'b1, 0);
    send_word(32'h1234_5678, 1'b0, 0);
    check_settle("recover");

    // Full-depth load: addresses 0..255.
    start_load();
    send_word(32'd256, 1'b0, 0);
    big_xor = '0;
    for (int i = 0; i < 256; i++) begin
      w = (i * 32'h0100_0193) + 32'h0000_0007;
      big_xor = big_xor ^ w;
      send_word(w, 1'b1, 0);
    end
    send_word(big_xor, 1'b0, 0);
    check_settle("full");
    check("full_writes_done", exp_q.size(), 0);

    // Reset in the middle of a 4-word frame, after the 2nd write is seen.
    start_load();
    send_word(32'd4, 1'b0, 0);
    send_word(32'hDEAD_BEEF, 1'b1, 0);
    send_word(32'h0BAD_F00D, 1'b1, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1 rst = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = 32'h0000_0004;
    for (int i = 0; i < 3; i++) begin
      check("postreset_ready", s_ready_o, 0);
      check("postreset_busy", busy_o, 0);
      tick();
    end
    s_valid_i = 1'b0;

    // start_i during LOAD and during SETTLE is ignored.
    start_load();
    send_word(32'd2, 1'b0, 0);
    send_word(32'h1111_1111, 1'b1, 0);
    start_i = 1'b1;
    send_word(32'h2222_2222, 1'b1, 0);
    start_i = 1'b0;
    send_word(32'h3333_3333, 1'b0, 0);
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("settle_start_busy", busy_o, 1);
    tick();
    check("settle_start_fetch_early", fetch_enable_o, 0);
    tick();
    check("settle_start_fetch_rise", fetch_enable_o, 1);
    check("settle_start_done", done_o, 1);
    tick();
    check("final_writes_done", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
